// File: rtl/mac_sequencer_if.sv
// Signal bundle between the MAC command sequencer, its operand/job source,
// the result consumer and the MAC itself.
interface mac_sequencer_if;
    logic        start;
    logic        mode;
    logic [7:0]  len;
    logic        sat;
    logic        job_busy;

    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;

    logic [2:0]  mac_instruction;
    logic [15:0] mac_multiplier;
    logic [15:0] mac_multiplicand;
    logic        mac_stall;
    logic [31:0] mac_result;
    logic [7:0]  mac_protect;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [7:0]  res_prot;

    // master is the sequencer; slave is everything around it
    modport master (
        input  start, mode, len, sat, op_valid, op_a, op_b,
               mac_result, mac_protect, res_ready,
        output job_busy, op_ready, mac_instruction, mac_multiplier,
               mac_multiplicand, mac_stall, res_valid, res_data, res_prot
    );

    modport slave (
        output start, mode, len, sat, op_valid, op_a, op_b,
               mac_result, mac_protect, res_ready,
        input  job_busy, op_ready, mac_instruction, mac_multiplier,
               mac_multiplicand, mac_stall, res_valid, res_data, res_prot
    );
endinterface

// File: rtl/mac_sequencer.sv
// Command-side driver for the pipelined MAC: streams a job's operand pairs,
// drains the MAC pipeline and returns the final result/protect word.
//
// state   | meaning
// IDLE    | waiting for start, MAC held on clear and stalled
// ISSUE   | streaming operand pairs, MAC stalled while starved
// SAT     | one saturate instruction
// DRAIN   | two clear cycles pushing the final instruction to mac_result
// CAPTURE | register mac_result / mac_protect
// DONE    | result presented until res_ready
module mac_sequencer (
    input  logic            clk,
    input  logic            reset,
    mac_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_SAT     = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        mode_q;
    logic        sat_q;
    logic        first;
    logic [8:0]  remaining;
    logic        drain_cnt;
    logic [31:0] res_data_q;
    logic [7:0]  res_prot_q;
    logic        last_pair;

    logic [2:0]  instr;
    logic [2:0]  base;
    logic        stall;
    logic        op_ready;
    logic [15:0] mult;
    logic [15:0] mcand;

    assign last_pair = bus.op_valid && (remaining == 9'd1);
    assign base      = {mode_q, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= 1'b0;
            sat_q      <= 1'b0;
            first      <= 1'b0;
            remaining  <= 9'd0;
            drain_cnt  <= 1'b0;
            res_data_q <= 32'd0;
            res_prot_q <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q    <= bus.mode;
                        sat_q     <= bus.sat;
                        first     <= 1'b1;
                        // len of zero encodes a full 256-pair job
                        remaining <= (bus.len == 8'd0) ? 9'd256 : {1'b0, bus.len};
                    end
                end
                S_ISSUE: begin
                    drain_cnt <= 1'b1;
                    if (bus.op_valid) begin
                        first     <= 1'b0;
                        remaining <= remaining - 9'd1;
                    end
                end
                S_SAT:     drain_cnt <= 1'b1;
                S_DRAIN:   drain_cnt <= drain_cnt - 1'b1;
                S_CAPTURE: begin
                    res_data_q <= bus.mac_result;
                    res_prot_q <= bus.mac_protect;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.start) state_nxt = S_ISSUE;
            S_ISSUE:   if (last_pair) state_nxt = sat_q ? S_SAT : S_DRAIN;
            S_SAT:     state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_cnt == 1'b0) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    if (bus.res_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        instr    = base;
        stall    = 1'b1;
        op_ready = 1'b0;
        mult     = 16'd0;
        mcand    = 16'd0;
        case (state)
            S_ISSUE: begin
                op_ready = 1'b1;
                instr    = first ? (base | 3'b001) : (base | 3'b010);
                stall    = ~bus.op_valid;
                mult     = bus.op_a;
                mcand    = bus.op_b;
            end
            S_SAT: begin
                instr = base | 3'b011;
                stall = 1'b0;
            end
            S_DRAIN: stall = 1'b0;
            default: ;
        endcase
    end

    assign bus.mac_instruction  = instr;
    assign bus.mac_stall        = stall;
    assign bus.mac_multiplier   = mult;
    assign bus.mac_multiplicand = mcand;
    assign bus.op_ready         = op_ready;
    assign bus.job_busy         = (state != S_IDLE);
    assign bus.res_valid        = (state == S_DONE);
    assign bus.res_data         = res_data_q;
    assign bus.res_prot         = res_prot_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural 3-stage MAC, job table plus hand-written
// reset sequence, result scoreboard.
module tb_mac_sequencer;
    logic clk = 1'b0;
    logic reset;

    mac_sequencer_if bus();

    mac_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_issue = 0;
    logic [2:0] issued[$];

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  prot;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic             mode;
        logic [7:0]       len;
        logic             sat;
        logic [2:0][15:0] a;
        logic [2:0][15:0] b;
        logic [3:0]       gap;
        logic [3:0]       bp;
        logic [31:0]      exp_data;
        logic [7:0]       exp_prot;
    } vec_t;

    // Log every instruction the MAC actually accepts
    always @(posedge clk) begin
        if (!reset && !bus.mac_stall) begin
            issued.push_back(bus.mac_instruction);
            if (bus.mac_instruction[1:0] != 2'b00) last_issue = cyc;
        end
        cyc = cyc + 1;
    end

    // MAC model: stage1 -> stage2 -> execute into result register
    logic [34:0]        s1, s2;
    logic signed [39:0] acc, nacc, pa, pb;
    logic signed [15:0] acc_hi, acc_lo, nh, nl, ha, hb, la, lb;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            acc <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            bus.mac_result <= '0;
            bus.mac_protect <= '0;
        end else if (!bus.mac_stall) begin
            s1 <= {bus.mac_instruction, bus.mac_multiplier, bus.mac_multiplicand};
            s2 <= s1;
            pa = {{24{s2[31]}}, s2[31:16]};
            pb = {{24{s2[15]}}, s2[15:0]};
            ha = {{8{s2[31]}}, s2[31:24]};
            hb = {{8{s2[15]}}, s2[15:8]};
            la = {{8{s2[23]}}, s2[23:16]};
            lb = {{8{s2[7]}}, s2[7:0]};
            nacc = acc;
            nh = acc_hi;
            nl = acc_lo;
            case (s2[33:32])
                2'd0: begin nacc = '0; nh = '0; nl = '0; end
                2'd1: begin nacc = pa * pb; nh = ha * hb; nl = la * lb; end
                2'd2: begin nacc = acc + pa * pb; nh = acc_hi + ha * hb; nl = acc_lo + la * lb; end
                default: begin
                    if (acc > 40'sh007FFFFFFF) nacc = 40'sh007FFFFFFF;
                    else if (acc < 40'shFF80000000) nacc = 40'shFF80000000;
                end
            endcase
            acc <= nacc;
            acc_hi <= nh;
            acc_lo <= nl;
            if (s2[34]) begin
                bus.mac_result <= {nh, nl};
                bus.mac_protect <= 8'd0;
            end else begin
                bus.mac_result <= nacc[31:0];
                bus.mac_protect <= (s2[33:32] == 2'd3) ? acc[39:32] : nacc[39:32];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mode, input logic [7:0] len, input logic sat,
                                input logic [15:0] a0, input logic [15:0] b0,
                                input logic [15:0] a1, input logic [15:0] b1,
                                input logic [15:0] a2, input logic [15:0] b2,
                                input logic [3:0] gap, input logic [3:0] bp,
                                input logic [31:0] d, input logic [7:0] p);
        vec_t v;
        v.mode = mode; v.len = len; v.sat = sat;
        v.a[0] = a0; v.b[0] = b0;
        v.a[1] = a1; v.b[1] = b1;
        v.a[2] = a2; v.b[2] = b2;
        v.gap = gap; v.bp = bp;
        v.exp_data = d; v.exp_prot = p;
        return v;
    endfunction

    task automatic run_job(input vec_t v);
        int npairs;
        int guard;
        logic [2:0] base;
        logic [2:0] exp_ins[$];
        exp_t e;
        npairs = (v.len == 8'd0) ? 256 : int'(v.len);
        issued.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode = v.mode;
        bus.len = v.len;
        bus.sat = v.sat;
        sb.push_back('{data: v.exp_data, prot: v.exp_prot});
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.job_busy), 32'd1);
        for (int i = 0; i < npairs; i++) begin
            if (i > 0) begin
                for (int g = 0; g < int'(v.gap); g++) begin
                    bus.op_valid = 1'b0;
                    #1 check("gap_stall", 32'(bus.mac_stall), 32'd1);
                    @(negedge clk);
                end
            end
            bus.op_valid = 1'b1;
            if (v.len == 8'd0) begin
                bus.op_a = 16'd1;
                bus.op_b = 16'd1;
            end else begin
                bus.op_a = v.a[2'(i)];
                bus.op_b = v.b[2'(i)];
            end
            #1;
            check("op_ready", 32'(bus.op_ready), 32'd1);
            check("issue_stall", 32'(bus.mac_stall), 32'd0);
            @(negedge clk);
        end
        bus.op_valid = 1'b0;

        guard = 0;
        while (bus.res_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL res_valid_timeout: got res_valid=%b expected 1 within 20 cycles", bus.res_valid);
        end else begin
            check("result_latency", 32'(cyc - last_issue), 32'd4);
        end

        for (int k = 0; k < int'(v.bp); k++) begin
            bus.start = (k == 1);
            @(negedge clk);
            check("bp_valid", 32'(bus.res_valid), 32'd1);
            check("bp_data", bus.res_data, v.exp_data);
            check("bp_busy", 32'(bus.job_busy), 32'd1);
        end
        bus.start = 1'b0;

        bus.res_ready = 1'b1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check("res_data", bus.res_data, e.data);
            check("res_prot", 32'(bus.res_prot), 32'(e.prot));
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("valid_fall", 32'(bus.res_valid), 32'd0);
        check("idle_busy", 32'(bus.job_busy), 32'd0);

        base = {v.mode, 2'b00};
        exp_ins.push_back(base | 3'b001);
        for (int i = 1; i < npairs; i++) exp_ins.push_back(base | 3'b010);
        if (v.sat) exp_ins.push_back(base | 3'b011);
        exp_ins.push_back(base);
        exp_ins.push_back(base);
        check("instr_count", 32'(issued.size()), 32'(exp_ins.size()));
        for (int i = 0; i < exp_ins.size() && i < issued.size(); i++)
            check("instr", 32'(issued[i]), 32'(exp_ins[i]));
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = mk(1'b0, 8'd3, 1'b0, 16'd3, 16'd4, 16'hFFFE, 16'd5, 16'd100, 16'd100,
                     4'd0, 4'd0, 32'h0000_2712, 8'h00);
        vecs[1] = mk(1'b0, 8'd2, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'd0, 16'd0,
                     4'd0, 4'd0, 32'h8000_0000, 8'h00);
        vecs[2] = mk(1'b0, 8'd2, 1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'd0, 16'd0,
                     4'd0, 4'd0, 32'h7FFF_FFFF, 8'h00);
        vecs[3] = mk(1'b1, 8'd1, 1'b0, 16'h7F80, 16'h02FF, 16'd0, 16'd0, 16'd0, 16'd0,
                     4'd0, 4'd0, 32'h00FE_0080, 8'h00);
        vecs[4] = mk(1'b0, 8'd3, 1'b0, 16'd3, 16'd4, 16'hFFFE, 16'd5, 16'd100, 16'd100,
                     4'd3, 4'd0, 32'h0000_2712, 8'h00);
        vecs[5] = mk(1'b0, 8'd3, 1'b0, 16'd3, 16'd4, 16'hFFFE, 16'd5, 16'd100, 16'd100,
                     4'd0, 4'd5, 32'h0000_2712, 8'h00);
        vecs[6] = mk(1'b0, 8'd0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                     4'd0, 4'd0, 32'h0000_0100, 8'h00);

        reset = 1'b1;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.len = 8'd0;
        bus.sat = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_a = 16'd0;
        bus.op_b = 16'd0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.job_busy), 32'd0);
        check("rst_op_ready", 32'(bus.op_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_res_prot", 32'(bus.res_prot), 32'd0);
        check("rst_stall", 32'(bus.mac_stall), 32'd1);
        check("rst_instr", 32'(bus.mac_instruction), 32'd0);
        check("rst_mult", 32'(bus.mac_multiplier), 32'd0);
        reset = 1'b0;

        for (int t = 0; t < 7; t++) run_job(vecs[t]);

        // Reset part-way through ISSUE discards the job
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode = 1'b0;
        bus.len = 8'd3;
        bus.sat = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_a = 16'd3;
        bus.op_b = 16'd4;
        @(negedge clk);
        check("mid_issue_busy", 32'(bus.job_busy), 32'd1);
        bus.op_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.job_busy), 32'd0);
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_stall", 32'(bus.mac_stall), 32'd1);
        check("mid_rst_op_ready", 32'(bus.op_ready), 32'd0);
        check("mid_rst_instr", 32'(bus.mac_instruction), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_job(mk(1'b0, 8'd1, 1'b0, 16'd7, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0,
                   4'd0, 4'd0, 32'h0000_002A, 8'h00));

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
